// File: rtl/rr_priority_encoder_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rr_priority_encoder_if : request/grant bundle for rr_priority_encoder        |
// | Rev 1.0 - initial release                                                    |
// +----------------------------------------------------------------------------+
interface rr_priority_encoder_if #(
  parameter int WIDTH = 12,
  parameter int IDX_W = 4
);
  logic [WIDTH-1:0] in;
  logic             req_valid;
  logic             mode;
  logic             ack;
  logic [IDX_W-1:0] out;
  logic             out_valid;
  logic             busy;
  logic             none;
`ifdef RR_PRIORITY_ENCODER_COUNT_EN
  logic [IDX_W:0]   pend_cnt;

  modport master (
    output in, req_valid, mode, ack,
    input  out, out_valid, busy, none, pend_cnt
  );
  modport slave (
    input  in, req_valid, mode, ack,
    output out, out_valid, busy, none, pend_cnt
  );
`else
  modport master (
    output in, req_valid, mode, ack,
    input  out, out_valid, busy, none
  );
  modport slave (
    input  in, req_valid, mode, ack,
    output out, out_valid, busy, none
  );
`endif
endinterface
`default_nettype wire

// File: rtl/rr_priority_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rr_priority_encoder : registered fixed/round-robin pending-request encoder  |
// | Optional RR_PRIORITY_ENCODER_COUNT_EN adds pend_cnt. Rev 1.0 - initial      |
// +----------------------------------------------------------------------------+
module rr_priority_encoder #(
  parameter int WIDTH = 12,
  parameter int IDX_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rr_priority_encoder_if.slave bus
);

  localparam logic [IDX_W-1:0] c_last = IDX_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] c_one  = WIDTH'(1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_pend, w_pend_nxt, w_req, w_cand;
  logic [IDX_W-1:0] r_ptr, w_ptr_nxt, r_out, w_out_nxt;
  logic             r_out_valid, r_busy, r_none, w_none_nxt;

  // rr=0: highest set index; rr=1: first set bit walking down from ptr, wrapping.
  function automatic logic [IDX_W-1:0] f_select(input logic [WIDTH-1:0] vec,
                                                input logic             rr,
                                                input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] idx;
    logic             hit;
    int               pos;
    idx = '0;
    hit = 1'b0;
    if (!rr) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (vec[IDX_W'(i)]) idx = IDX_W'(i);
      end
    end else begin
      for (int k = 0; k < WIDTH; k++) begin
        pos = int'(ptr) - k;
        if (pos < 0) pos = pos + WIDTH;
        if (!hit && vec[IDX_W'(pos)]) begin
          idx = IDX_W'(pos);
          hit = 1'b1;
        end
      end
    end
    return idx;
  endfunction

  always_comb begin
    w_req       = bus.req_valid ? bus.in : '0;
    w_state_nxt = r_state;
    w_pend_nxt  = r_pend;
    w_ptr_nxt   = r_ptr;
    w_out_nxt   = r_out;
    w_none_nxt  = 1'b0;
    w_cand      = '0;
    case (r_state)
      ST_IDLE: begin
        if (bus.req_valid) begin
          if (bus.in != '0) begin
            w_pend_nxt  = bus.in;
            w_state_nxt = ST_HOLD;
            w_out_nxt   = f_select(bus.in, bus.mode, r_ptr);
          end else begin
            w_none_nxt = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (bus.ack) begin
          w_pend_nxt = (r_pend & ~(c_one << r_out)) | w_req;
          w_ptr_nxt  = (r_out == '0) ? c_last : r_out - IDX_W'(1);
          w_out_nxt  = f_select(w_pend_nxt, bus.mode, w_ptr_nxt);
        end else begin
          // An unacked grant may only be displaced by a newly arriving bit that outranks it.
          w_pend_nxt = r_pend | w_req;
          w_cand     = (c_one << r_out) | w_req;
          w_out_nxt  = f_select(w_cand, bus.mode, r_ptr);
        end
        if (w_pend_nxt == '0) begin
          w_state_nxt = ST_IDLE;
          w_out_nxt   = r_out;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_pend      <= '0;
      r_ptr       <= c_last;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_none      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pend      <= w_pend_nxt;
      r_ptr       <= w_ptr_nxt;
      r_out       <= w_out_nxt;
      r_out_valid <= (w_state_nxt == ST_HOLD);
      r_busy      <= (w_state_nxt == ST_HOLD);
      r_none      <= w_none_nxt;
    end
  end

  assign bus.out       = r_out;
  assign bus.out_valid = r_out_valid;
  assign bus.busy      = r_busy;
  assign bus.none      = r_none;

`ifdef RR_PRIORITY_ENCODER_COUNT_EN
  logic [IDX_W:0] r_pend_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_cnt <= '0;
    end else begin
      r_pend_cnt <= (IDX_W + 1)'($countones(w_pend_nxt));
    end
  end

  assign bus.pend_cnt = r_pend_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rr_priority_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_rr_priority_encoder : directed scoreboard bench for rr_priority_encoder  |
// | Rev 1.0 - initial release                                                    |
// +----------------------------------------------------------------------------+
module tb_rr_priority_encoder;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  rr_priority_encoder_if #(.WIDTH(12), .IDX_W(4)) bus ();

  rr_priority_encoder #(.WIDTH(12), .IDX_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [3:0] out;
    logic       ov;
    logic       busy;
    logic       none;
    int         cnt;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic step(input logic [11:0] vin, input logic vrv, input logic vack,
                      input logic vmode, input logic [3:0] eo, input logic eov,
                      input logic eb, input logic en, input int ec, input string tag);
    exp_t e;
    bus.in        = vin;
    bus.req_valid = vrv;
    bus.ack       = vack;
    bus.mode      = vmode;
    sb.push_back('{tag, eo, eov, eb, en, ec});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({e.tag, ".out"},   32'(bus.out),       32'(e.out));
    chk({e.tag, ".valid"}, 32'(bus.out_valid), 32'(e.ov));
    chk({e.tag, ".busy"},  32'(bus.busy),      32'(e.busy));
    chk({e.tag, ".none"},  32'(bus.none),      32'(e.none));
`ifdef RR_PRIORITY_ENCODER_COUNT_EN
    if (e.cnt >= 0) chk({e.tag, ".cnt"}, 32'(bus.pend_cnt), 32'(e.cnt));
`endif
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in        = '0;
    bus.req_valid = 1'b0;
    bus.ack       = 1'b0;
    bus.mode      = 1'b0;

    // 1: reset holds outputs at zero regardless of inputs
    for (int i = 0; i < 4; i++) begin
      bus.in        = 12'($urandom);
      bus.req_valid = 1'($urandom_range(0, 1));
      bus.ack       = 1'($urandom_range(0, 1));
      bus.mode      = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      chk("t1.rst.out",   32'(bus.out),       32'd0);
      chk("t1.rst.valid", 32'(bus.out_valid), 32'd0);
      chk("t1.rst.busy",  32'(bus.busy),      32'd0);
      chk("t1.rst.none",  32'(bus.none),      32'd0);
    end
    bus.req_valid = 1'b0;
    bus.ack       = 1'b0;
    bus.in        = '0;
    rst_n         = 1'b1;
    step(12'h000, 0, 0, 0, 4'd0, 0, 0, 0, 0, "t1.idle0");
    step(12'h000, 0, 1, 0, 4'd0, 0, 0, 0, 0, "t1.idle1");

    // 2: fixed priority drain with ack held
    step(12'h810, 1, 1, 0, 4'd11, 1, 1, 0, 2, "t2.cap");
    step(12'h000, 0, 1, 0, 4'd4,  1, 1, 0, 1, "t2.g1");
    step(12'h000, 0, 1, 0, 4'd4,  0, 0, 0, 0, "t2.done");

    // 3: empty request in IDLE pulses none; in HOLD it is ignored
    step(12'h000, 1, 0, 0, 4'd4, 0, 0, 1, 0, "t3.none");
    step(12'h000, 0, 0, 0, 4'd4, 0, 0, 0, 0, "t3.none_end");
    step(12'h001, 1, 0, 0, 4'd0, 1, 1, 0, 1, "t3.cap");
    step(12'h000, 1, 0, 0, 4'd0, 1, 1, 0, 1, "t3.hold_empty");
    step(12'h000, 0, 1, 0, 4'd0, 0, 0, 0, 0, "t3.done");

    // 4: round-robin with merge, then same stimulus in fixed mode
    step(12'h005, 1, 0, 1, 4'd2, 1, 1, 0, 2, "t4.rr.cap");
    step(12'h104, 1, 1, 1, 4'd0, 1, 1, 0, 3, "t4.rr.merge");
    step(12'h000, 0, 1, 1, 4'd8, 1, 1, 0, 2, "t4.rr.g8");
    step(12'h000, 0, 1, 1, 4'd2, 1, 1, 0, 1, "t4.rr.g2");
    step(12'h000, 0, 1, 1, 4'd2, 0, 0, 0, 0, "t4.rr.done");
    step(12'h005, 1, 0, 0, 4'd2, 1, 1, 0, 2, "t4.fx.cap");
    step(12'h104, 1, 1, 0, 4'd8, 1, 1, 0, 3, "t4.fx.merge");
    step(12'h000, 0, 1, 0, 4'd2, 1, 1, 0, 2, "t4.fx.g2");
    step(12'h000, 0, 1, 0, 4'd0, 1, 1, 0, 1, "t4.fx.g0");
    step(12'h000, 0, 1, 0, 4'd0, 0, 0, 0, 0, "t4.fx.done");

    // 4b: switching mode under an unacked grant keeps that grant
    step(12'h005, 1, 0, 1, 4'd0 + 4'd2, 1, 1, 0, 2, "t4b.cap");
    step(12'h104, 1, 1, 1, 4'd0, 1, 1, 0, 3, "t4b.merge");
    step(12'h000, 0, 0, 0, 4'd0, 1, 1, 0, 3, "t4b.modesw");
    step(12'h000, 0, 1, 0, 4'd8, 1, 1, 0, 2, "t4b.g8");
    step(12'h000, 0, 1, 0, 4'd2, 1, 1, 0, 1, "t4b.g2");
    step(12'h000, 0, 1, 0, 4'd2, 0, 0, 0, 0, "t4b.done");

    // 5: higher bit preempts an unacked grant; async reset mid-HOLD
    step(12'h001, 1, 0, 0, 4'd0, 1, 1, 0, 1, "t5.cap");
    step(12'h100, 1, 0, 0, 4'd8, 1, 1, 0, 2, "t5.preempt");
    bus.req_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5.arst.out",   32'(bus.out),       32'd0);
    chk("t5.arst.valid", 32'(bus.out_valid), 32'd0);
    chk("t5.arst.busy",  32'(bus.busy),      32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(12'h000, 0, 0, 1, 4'd0, 0, 0, 0, 0, "t5.post_rst");

    // 6: full vector in round-robin from the reset pointer, one grant per cycle
    step(12'hFFF, 1, 0, 1, 4'd11, 1, 1, 0, 12, "t6.cap");
    for (int k = 1; k < 12; k++) begin
      step(12'h000, 0, 1, 1, 4'(11 - k), 1, 1, 0, 12 - k, "t6.drain");
    end
    step(12'h000, 0, 1, 1, 4'd0, 0, 0, 0, 0, "t6.done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rr_priority_encoder.md
Name: rr_priority_encoder

Overview:
Parametrised, registered successor to the combinational 12-bit priority encoder. It captures a request vector and emits the encoded index of one set bit per handshake. Each acknowledged bit is cleared, and new requests can merge in while draining. MODE selects fixed MSB-first priority or a rotating round-robin pointer; the block feeds the request-servicing logic downstream of the input-sampling stage.

Parameters:
WIDTH, 12, number of request lines
IDX_W, 4, width of encoded index; must satisfy 2**IDX_W >= WIDTH

Ports:
CLK  input  1  rising-edge clock
RST_N  input  1  asynchronous active-low reset
IN  input  WIDTH  request vector
REQ_VALID  input  1  IN is sampled and ORed into pending set this edge
MODE  input  1  0 = fixed priority (highest index wins), 1 = round-robin
ACK  input  1  consumer accepts current OUT this edge
OUT  output  IDX_W  encoded index of selected pending bit
OUT_VALID  output  1  OUT is meaningful
BUSY  output  1  pending set non-empty (state HOLD)
NONE  output  1  one-cycle pulse: REQ_VALID seen in IDLE with IN == 0

Behaviour:
- Internal state: PEND[WIDTH-1:0], PTR[IDX_W-1:0], FSM {IDLE, HOLD}.
- Reset (async, RST_N=0): PEND=0, PTR=WIDTH-1, state IDLE, OUT=0, OUT_VALID=0, BUSY=0, NONE=0. Takes effect immediately, including mid-HOLD. Nothing pending survives reset.
- All outputs are registered. After each edge they reflect PEND/PTR/state as updated at that edge.
- IDLE transitions:
  - REQ_VALID=1 and IN != 0: PEND=IN, go to HOLD.
  - REQ_VALID=1 and IN == 0: stay in IDLE, NONE=1 for exactly one cycle.
  - ACK is ignored in IDLE.
- HOLD, next PEND = (ACK ? PEND with bit OUT cleared : PEND) | (REQ_VALID ? IN : 0).
  - A re-request of the granted bit in the same cycle keeps that bit set.
  - If next PEND == 0: go to IDLE, OUT_VALID=0, BUSY=0, OUT holds its last value.
- Selection, evaluated on next PEND:
  - MODE=0: highest set index.
  - MODE=1: first set bit searching downward from PTR, wrapping from 0 to WIDTH-1.
- PTR update: only on ACK in HOLD, PTR = (OUT == 0) ? WIDTH-1 : OUT-1. This happens in both modes; PTR is not used when MODE=0.
- MODE is sampled every edge. A change mid-HOLD affects only the next selection, never a grant already presented.
- Latency: capture edge to OUT_VALID=1 is 1 cycle. Throughput is one grant per cycle with ACK held high.
- OUT must not change while OUT_VALID=1 and ACK=0, unless REQ_VALID adds a higher-priority bit. MODE=0: a higher index. MODE=1: a bit earlier in the search order from PTR.
- Index arithmetic is modulo WIDTH, not 2**IDX_W; OUT never exceeds WIDTH-1.

Optional Feature:
Macro RR_PRIORITY_ENCODER_COUNT_EN.
- Defined: adds output PEND_CNT (IDX_W+1 bits), a registered population count of PEND, updated on the same edge as PEND. Reset value 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
1. Assert RST_N=0 with random IN/REQ_VALID/ACK -> OUT=0, OUT_VALID=0, BUSY=0, NONE=0. Release RST_N -> outputs unchanged until the next request.
2. MODE=0, REQ_VALID pulse with IN=12'b1000_0001_0000, ACK held 1 -> cycle+1 OUT=11, cycle+2 OUT=4, cycle+3 OUT_VALID=0, BUSY=0.
3. REQ_VALID with IN=0 in IDLE -> NONE=1 for one cycle, OUT_VALID remains 0. Same stimulus in HOLD -> NONE stays 0, PEND unchanged.
4. MODE=1 round-robin with merge:
   - Capture IN=12'b0000_0000_0101 -> OUT=2.
   - ACK together with REQ_VALID, IN=12'b0001_0000_0100 -> OUT=0.
   - ACK -> OUT=8. ACK -> OUT=2. ACK -> IDLE.
   - Same stimulus with MODE=0 -> order is 2, 8, 2, 0.
5. MODE=0, capture IN=12'b0000_0000_0001, hold ACK=0, then REQ_VALID with IN=12'b0001_0000_0000 -> OUT switches 0 to 8 and OUT_VALID stays 1. Assert RST_N=0 mid-HOLD -> OUT_VALID drops before the next CLK edge; after release, PTR=11 (first MODE=1 grant of IN=12'hFFF is 11).
6. With RR_PRIORITY_ENCODER_COUNT_EN: capture IN=12'hFFF -> PEND_CNT=12, decrementing by 1 per ACK down to 0. Without the macro the bench compiles and passes tests 1-5 unchanged.
